queue_n_to_1: RTL and testbench

- Parametrised width-narrowing FIFO and the successor of the fixed 2:1 queue.
- Each push writes a variable number of Width-bit words, from 1 up to Ratio, taken from a wide input bus.
- Each pull removes exactly one Width-bit word.
- Sits between wide producers (parallel fitness/genome units) and narrow serial consumers. Adds fill-level reporting and a sticky error flag.

---
 rtl/queue_n_to_1.sv | 105 ++++++++++
 tb/tb_queue_n_to_1.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_n_to_1.sv
// queue_n_to_1: width-narrowing FIFO. Each push writes 1..Ratio words of
// Width bits from a wide bus; each pull removes exactly one word.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         asynchronous active-high reset (discards contents)
//   push_i        write request
//   push_count_i  words to write this push (0 = no-op, >Ratio = rejected)
//   pull_i        read request, removes the head word
//   d_i           input words; d_i[Width-1:0] is word 0 and leaves first
//   q_o           head word, first-word fall-through, 0 when empty
//   void_o        queue empty
//   full_o        free space < Ratio
//   level_o       words stored, 0..Depth
//   err_o         sticky error: rejected push or pull from empty
module queue_n_to_1 #(
    parameter int Width        = 8,
    parameter int AddressWidth = 2,
    parameter int Ratio        = 2,
    parameter int CountWidth   = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push_i,
    input  logic [CountWidth-1:0]     push_count_i,
    input  logic                      pull_i,
    input  logic [Width*Ratio-1:0]    d_i,
    output logic [Width-1:0]          q_o,
    output logic                      void_o,
    output logic                      full_o,
    output logic [AddressWidth:0]     level_o,
    output logic                      err_o
);

    localparam int Depth = 2 ** AddressWidth;
    localparam logic [AddressWidth:0] DepthLvl = (AddressWidth + 1)'(Depth);

    logic [Width-1:0]        mem_q [Depth];
    logic [AddressWidth-1:0] head_q, head_d;
    logic [AddressWidth-1:0] tail_q, tail_d;
    logic [AddressWidth:0]   level_q, level_d;
    logic                    err_q, err_d;

    logic [AddressWidth:0]   free_lvl;
    logic [31:0]             cnt_w;
    logic [31:0]             free_w;
    logic                    push_ok;
    logic                    push_reject;
    logic                    pull_ok;
    logic                    pull_reject;
    logic [AddressWidth:0]   push_add;
    logic [AddressWidth:0]   pull_sub;

    // Free space is taken from the pre-edge level, so a push alongside a
    // pull cannot use the slot the pull is about to release.
    assign free_lvl = DepthLvl - level_q;
    assign cnt_w    = 32'(push_count_i);
    assign free_w   = 32'(free_lvl);

    always_comb begin
        push_ok     = push_i && (cnt_w != 32'd0) && (cnt_w <= 32'(Ratio)) && (cnt_w <= free_w);
        push_reject = push_i && (cnt_w != 32'd0) && !push_ok;
        pull_ok     = pull_i && (level_q != '0);
        pull_reject = pull_i && (level_q == '0);

        push_add = push_ok ? (AddressWidth + 1)'(push_count_i) : '0;
        pull_sub = {{AddressWidth{1'b0}}, pull_ok};

        // Pointers are AddressWidth bits, so the adds wrap modulo Depth.
        head_d  = head_q + AddressWidth'(pull_ok);
        tail_d  = tail_q + (push_ok ? AddressWidth'(push_count_i) : '0);
        level_d = level_q + push_add - pull_sub;
        err_d   = err_q | push_reject | pull_reject;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
            err_q   <= err_d;
        end
    end

    // Storage is not reset; level alone decides what is valid.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < Ratio; k++) begin
            if (push_ok && (32'(k) < cnt_w)) begin
                mem_q[tail_q + AddressWidth'(k)] <= d_i[k*Width +: Width];
            end
        end
    end

    assign q_o     = (level_q != '0) ? mem_q[head_q] : '0;
    assign void_o  = (level_q == '0);
    assign full_o  = (free_w < 32'(Ratio));
    assign level_o = level_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_queue_n_to_1.sv
// tb_queue_n_to_1: directed vectors on the default configuration
// (Width=8, AddressWidth=2, Ratio=2) plus a random soak against a queue
// model on both the default and a Ratio=4, AddressWidth=3 instance.
module tb_queue_n_to_1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rst;

    logic        a_push, a_pull;
    logic [1:0]  a_cnt;
    logic [15:0] a_d;
    logic [7:0]  a_q;
    logic        a_void, a_full, a_err;
    logic [2:0]  a_level;

    logic        b_push, b_pull;
    logic [2:0]  b_cnt;
    logic [31:0] b_d;
    logic [7:0]  b_q;
    logic        b_void, b_full, b_err;
    logic [3:0]  b_level;

    queue_n_to_1 #(.Width(8), .AddressWidth(2), .Ratio(2), .CountWidth(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .push_i(a_push), .push_count_i(a_cnt),
        .pull_i(a_pull), .d_i(a_d), .q_o(a_q), .void_o(a_void),
        .full_o(a_full), .level_o(a_level), .err_o(a_err)
    );

    queue_n_to_1 #(.Width(8), .AddressWidth(3), .Ratio(4), .CountWidth(3)) dut_b (
        .clk_i(clk), .rst_i(rst), .push_i(b_push), .push_count_i(b_cnt),
        .pull_i(b_pull), .d_i(b_d), .q_o(b_q), .void_o(b_void),
        .full_o(b_full), .level_o(b_level), .err_o(b_err)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic p, input logic [1:0] c, input logic [15:0] d, input logic pl);
        a_push = p;
        a_cnt  = c;
        a_d    = d;
        a_pull = pl;
    endtask

    task automatic a_expect(input string tag, input logic [7:0] q, input logic [2:0] lvl,
                            input logic vd, input logic fl, input logic er);
        check_val({tag, ".q"},     32'(a_q),     32'(q));
        check_val({tag, ".level"}, 32'(a_level), 32'(lvl));
        check_val({tag, ".void"},  32'(a_void),  32'(vd));
        check_val({tag, ".full"},  32'(a_full),  32'(fl));
        check_val({tag, ".err"},   32'(a_err),   32'(er));
    endtask

    // Asynchronous reset pulse placed mid-cycle, away from any clock edge.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        check_val("rst.a_void",  32'(a_void),  32'd1);
        check_val("rst.a_level", 32'(a_level), 32'd0);
        check_val("rst.a_err",   32'(a_err),   32'd0);
        rst = 1'b0;
    endtask

    // Send one word per pull and check the head before each pull.
    task automatic a_drain(input string tag, input logic [31:0] seq);
        for (int k = 0; k < 4; k++) begin
            check_val(tag, 32'(a_q), 32'(seq[31 - 8*k -: 8]));
            a_drive(1'b0, 2'd0, 16'h0, 1'b1);
            step();
        end
        a_drive(1'b0, 2'd0, 16'h0, 1'b0);
    endtask

    logic [7:0] ma[$];
    logic [7:0] mb[$];
    logic       ma_err, mb_err;

    initial begin
        logic       pa, pla, pb, plb;
        int         ca, cb;
        logic [15:0] da;
        logic [31:0] db;

        rst = 1'b0;
        a_drive(1'b0, 2'd0, 16'h0, 1'b0);
        b_push = 1'b0; b_cnt = '0; b_d = '0; b_pull = 1'b0;

        // Reset with no clock edge in between
        #2;
        rst = 1'b1;
        #1;
        a_expect("reset", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;

        // Basic push and drain
        a_drive(1'b1, 2'd2, 16'hBBAA, 1'b0);
        step();
        a_drive(1'b0, 2'd0, 16'h0, 1'b0);
        // free = 2 equals Ratio, so not full yet
        a_expect("push2", 8'hAA, 3'd2, 1'b0, 1'b0, 1'b0);
        a_drive(1'b0, 2'd0, 16'h0, 1'b1);
        step();
        a_expect("pull1", 8'hBB, 3'd1, 1'b0, 1'b0, 1'b0);
        step();
        a_drive(1'b0, 2'd0, 16'h0, 1'b0);
        a_expect("pull2", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);

        // Fill and overflow
        a_drive(1'b1, 2'd2, 16'h2211, 1'b0);
        step();
        a_drive(1'b1, 2'd2, 16'h4433, 1'b0);
        step();
        a_drive(1'b0, 2'd0, 16'h0, 1'b0);
        a_expect("fill", 8'h11, 3'd4, 1'b0, 1'b1, 1'b0);
        a_drive(1'b1, 2'd2, 16'h6655, 1'b0);
        step();
        a_drive(1'b0, 2'd0, 16'h0, 1'b0);
        a_expect("overflow", 8'h11, 3'd4, 1'b0, 1'b1, 1'b1);
        a_drain("drain_fill", 32'h11223344);
        a_expect("drained", 8'h00, 3'd0, 1'b1, 1'b0, 1'b1);

        // Partial push at the boundary
        async_reset();
        a_drive(1'b1, 2'd2, 16'h2211, 1'b0);
        step();
        a_drive(1'b1, 2'd1, 16'hEE33, 1'b0);
        step();
        a_drive(1'b0, 2'd0, 16'h0, 1'b0);
        a_expect("level3", 8'h11, 3'd3, 1'b0, 1'b1, 1'b0);
        a_drive(1'b1, 2'd1, 16'hDDCC, 1'b0);
        step();
        a_drive(1'b0, 2'd0, 16'h0, 1'b0);
        a_expect("partial", 8'h11, 3'd4, 1'b0, 1'b1, 1'b0);
        a_drive(1'b1, 2'd3, 16'hFFFF, 1'b0);
        step();
        a_drive(1'b0, 2'd0, 16'h0, 1'b0);
        a_expect("count3", 8'h11, 3'd4, 1'b0, 1'b1, 1'b1);
        a_drain("drain_partial", 32'h112233CC);

        // Zero-count push, simultaneous push/pull, underflow
        async_reset();
        a_drive(1'b1, 2'd0, 16'hFFFF, 1'b0);
        step();
        a_expect("count0", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
        a_drive(1'b1, 2'd2, 16'h2211, 1'b0);
        step();
        a_expect("pre_simul", 8'h11, 3'd2, 1'b0, 1'b0, 1'b0);
        a_drive(1'b1, 2'd2, 16'h4433, 1'b1);
        step();
        a_drive(1'b0, 2'd0, 16'h0, 1'b0);
        a_expect("simul", 8'h22, 3'd3, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check_val("simul_order", 32'(a_q), 32'(8'h22 + 8'h11 * k));
            a_drive(1'b0, 2'd0, 16'h0, 1'b1);
            step();
        end
        a_drive(1'b0, 2'd0, 16'h0, 1'b1);
        step();
        a_drive(1'b0, 2'd0, 16'h0, 1'b0);
        a_expect("underflow", 8'h00, 3'd0, 1'b1, 1'b0, 1'b1);

        // A push does not rescue a pull from empty
        async_reset();
        a_drive(1'b1, 2'd1, 16'h0077, 1'b1);
        step();
        a_drive(1'b0, 2'd0, 16'h0, 1'b0);
        a_expect("push_pull_empty", 8'h77, 3'd1, 1'b0, 1'b0, 1'b1);

        // Random soak on both instances against queue models
        async_reset();
        ma.delete();
        mb.delete();
        ma_err = 1'b0;
        mb_err = 1'b0;
        for (int i = 0; i < 500; i++) begin
            check_val("soak_a.q",     32'(a_q),     32'(ma.size() != 0 ? ma[0] : 8'h00));
            check_val("soak_a.level", 32'(a_level), 32'(ma.size()));
            check_val("soak_a.void",  32'(a_void),  32'(ma.size() == 0));
            check_val("soak_a.full",  32'(a_full),  32'((4 - ma.size()) < 2));
            check_val("soak_a.err",   32'(a_err),   32'(ma_err));
            check_val("soak_b.q",     32'(b_q),     32'(mb.size() != 0 ? mb[0] : 8'h00));
            check_val("soak_b.level", 32'(b_level), 32'(mb.size()));
            check_val("soak_b.void",  32'(b_void),  32'(mb.size() == 0));
            check_val("soak_b.full",  32'(b_full),  32'((8 - mb.size()) < 4));
            check_val("soak_b.err",   32'(b_err),   32'(mb_err));

            if (i == 250) begin
                a_drive(1'b0, 2'd0, 16'h0, 1'b0);
                b_push = 1'b0; b_cnt = '0; b_pull = 1'b0;
                #2;
                rst = 1'b1;
                #1;
                check_val("mid_rst.a_void", 32'(a_void), 32'd1);
                check_val("mid_rst.b_void", 32'(b_void), 32'd1);
                check_val("mid_rst.b_level", 32'(b_level), 32'd0);
                rst = 1'b0;
                ma.delete();
                mb.delete();
                ma_err = 1'b0;
                mb_err = 1'b0;
            end else begin
                pa  = ($urandom_range(0, 3) != 0) && ((4 - ma.size()) >= 2);
                ca  = $urandom_range(0, 2);
                da  = 16'($urandom);
                pla = ($urandom_range(0, 2) != 0) && (ma.size() != 0);
                pb  = ($urandom_range(0, 3) != 0) && ((8 - mb.size()) >= 4);
                cb  = $urandom_range(0, 4);
                db  = $urandom;
                plb = ($urandom_range(0, 2) != 0) && (mb.size() != 0);
                a_drive(pa, 2'(ca), da, pla);
                b_push = pb; b_cnt = 3'(cb); b_d = db; b_pull = plb;

                if (pla) void'(ma.pop_front());
                if (pa) for (int k = 0; k < ca; k++) ma.push_back(da[8*k +: 8]);
                if (plb) void'(mb.pop_front());
                if (pb) for (int k = 0; k < cb; k++) mb.push_back(db[8*k +: 8]);
            end
            step();
        end
        a_drive(1'b0, 2'd0, 16'h0, 1'b0);
        b_push = 1'b0; b_pull = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
